// File: rtl/div_seq_pkg.sv
// Shared definitions for the iterative divider sequencer.
//   - State encoding for the div_seq FSM.
//   - Default operand width and the matching iteration-counter width.
//   - MIPS SPECIAL-function codes the decode stage maps onto start_i/signed_i.
package div_seq_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultCntW  = $clog2(DefaultWidth);

    localparam logic [1:0] StateIdle = 2'd0;
    localparam logic [1:0] StateZero = 2'd1;
    localparam logic [1:0] StateBusy = 2'd2;
    localparam logic [1:0] StateDone = 2'd3;

    typedef enum logic [1:0] {
        StIdle = StateIdle,
        StZero = StateZero,
        StBusy = StateBusy,
        StDone = StateDone
    } state_e;

    // SPECIAL opcode function field values for the MDU divide ops.
    localparam logic [5:0] OpcodeSpecial = 6'h00;
    localparam logic [5:0] FunctDiv      = 6'h1a;
    localparam logic [5:0] FunctDivu     = 6'h1b;

    // Decode helpers: does this function code start a divide, and is it signed?
    function automatic logic mdu_is_div(input logic [5:0] funct);
        return (funct == FunctDiv) || (funct == FunctDivu);
    endfunction

    function automatic logic mdu_is_signed(input logic [5:0] funct);
        return funct == FunctDiv;
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One combinational restoring-division iteration.
// Ports:
//   rem_i      current partial remainder (always < divisor_i)
//   divisor_i  divisor magnitude
//   bit_i      next dividend bit shifted into the remainder
//   rem_o      next partial remainder
//   q_o        quotient bit produced by this step
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   part;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        part = {rem_i, bit_i};
        ge   = part >= {1'b0, divisor_i};
        // When ge holds the difference is below the divisor, so WIDTH bits suffice.
        diff = part[WIDTH-1:0] - divisor_i;
        rem_o = ge ? diff : part[WIDTH-1:0];
        q_o   = ge;
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start_i     request strobe, accepted in IDLE or DONE
//   signed_i    1 = DIV (two's complement), 0 = DIVU
//   annul_i     flush/exception; aborts any operation, beats start_i
//   a_i, b_i    dividend and divisor, sampled at acceptance
//   result_o    registered {remainder (HI), quotient (LO)}
//   ready_o     one-cycle pulse when result_o is newly valid
//   busy_o      stall request while a division occupies the unit
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    // Holds the remaining dividend bits in the top and the quotient built so far in the bottom.
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   q_next;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               accept;
    logic               last_step;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .divisor_i (dvsr_q),
        .bit_i     (quo_q[WIDTH-1]),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;

        // The most negative value maps onto itself, which is the correct magnitude unsigned.
        a_abs = (signed_i && a_i[WIDTH-1]) ? ('0 - a_i) : a_i;
        b_abs = (signed_i && b_i[WIDTH-1]) ? ('0 - b_i) : b_i;

        q_next    = {quo_q[WIDTH-2:0], step_q};
        q_fix     = neg_q_q ? ('0 - q_next) : q_next;
        r_fix     = neg_r_q ? ('0 - step_rem) : step_rem;
        last_step = cnt_q == CntW'(WIDTH - 1);
        accept    = start_i && !annul_i && ((state_q == StIdle) || (state_q == StDone));

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    rem_d   = '0;
                    quo_d   = a_abs;
                    dvsr_d  = b_abs;
                    neg_q_d = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    neg_r_d = signed_i && a_i[WIDTH-1];
                    cnt_d   = '0;
                    state_d = (b_i == '0) ? StZero : StBusy;
                end
            end
            StZero: begin
                result_d = '0;
                state_d  = StDone;
            end
            StBusy: begin
                rem_d = step_rem;
                quo_d = q_next;
                cnt_d = cnt_q + CntW'(1);
                if (last_step) begin
                    result_d = {r_fix, q_fix};
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        // Annul discards the operation and leaves the previous result visible.
        if (annul_i) begin
            state_d  = StIdle;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = state_q == StDone;
    assign busy_o   = (state_q == StBusy) || (state_q == StZero);

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle iterative divider sequencer for the MIPS execute stage.
- Covers the DIV/DIVU cases that the single-cycle ALU cannot handle.
- Accepts one request at a time and runs a radix-2 restoring division over WIDTH cycles.
- Asserts busy_o so hazard logic stalls the pipeline, then delivers {remainder, quotient} for the HI/LO registers with a one-cycle ready_o pulse.

Parameters:
- WIDTH, 32, operand width in bits; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request strobe; accepted only in IDLE or DONE.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- annul_i  in  1  flush or exception; aborts any operation in progress.
- a_i  in  WIDTH  dividend, sampled at acceptance.
- b_i  in  WIDTH  divisor, sampled at acceptance.
- result_o  out  2*WIDTH  {remainder (HI), quotient (LO)}; registered.
- ready_o  out  1  one-cycle pulse when result_o is newly valid.
- busy_o  out  1  high while a division occupies the unit; pipeline stall request.

Behaviour:
- Clocking and reset:
  - Single clock clk.
  - rst is synchronous and active-high.
  - On rst: state = IDLE, result_o = 0, ready_o = 0, busy_o = 0, counter = 0.
  - Reset asserted mid-operation discards the operation. No ready_o is produced.
- States:
  - IDLE: waiting for a request.
  - ZERO: divide-by-zero path.
  - BUSY: iterating.
  - DONE: result presented.
- busy_o = (state == BUSY or ZERO). ready_o = (state == DONE).
- Acceptance:
  - At an edge where state is IDLE or DONE and start_i = 1 and annul_i = 0, the block latches signed_i, a_i and b_i.
  - If b_i == 0: go to ZERO.
  - Otherwise go to BUSY with counter = 0.
  - In signed mode, latch |a| and |b|, plus neg_q = a[MSB] ^ b[MSB] and neg_r = a[MSB].
- BUSY:
  - Each edge performs one restoring step: partial remainder = {rem, next dividend bit}. If it is >= divisor, subtract and shift in quotient bit 1; else shift in 0.
  - counter increments each step.
  - On the step with counter == WIDTH-1: apply sign fixup, write result_o, go to DONE.
  - Sign fixup: negate the quotient if neg_q; negate the remainder if neg_r. Unsigned mode applies no fixup.
- ZERO: the next edge writes result_o = 0 and goes to DONE.
- Latency:
  - Request accepted at edge k.
  - Normal path: ready_o is high for the cycle after edge k+WIDTH, i.e. after 32 stall cycles at the default WIDTH.
  - Divide-by-zero path: ready_o is high for the cycle after edge k+1.
- DONE:
  - Lasts exactly one cycle.
  - Returns to IDLE, or goes directly to ZERO/BUSY if a new start_i is accepted that cycle (back-to-back operation).
- start_i while in BUSY or ZERO is ignored. No queueing.
- annul_i = 1 at any edge:
  - state goes to IDLE and any pending operation is discarded.
  - result_o keeps its previous value. No ready_o follows.
  - annul_i has priority over a simultaneous start_i.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. Modular wrap; no trap.
- result_o changes only on the edge that enters DONE, and otherwise holds.

Decomposition:
- Shared package:
  - State encoding (IDLE, ZERO, BUSY, DONE) as localparams.
  - Default WIDTH.
  - Counter width = clog2(WIDTH).
  - The ALU/MDU op codes that the decode stage uses to drive start_i and signed_i.
- Sub-module div_step:
  - Purely combinational single restoring iteration.
  - Inputs: partial remainder, divisor, incoming dividend bit.
  - Outputs: next remainder, quotient bit.
  - Instantiated once; the FSM iterates it.

Test Plan:
- Unsigned basic: DIVU a=100, b=7 at edge k -> busy_o high for 32 cycles; ready_o high after edge k+32; result_o = {0x00000002, 0x0000000E}.
- Signed sign fixup: DIV a=0xFFFFFFF9 (-7), b=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIV 7 / -2 -> q=0xFFFFFFFD, r=0x00000001.
- Divide by zero: DIV a=5, b=0 -> busy_o high one cycle; ready_o after edge k+1; result_o = 0.
- Overflow and extremes:
  - Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
  - Unsigned 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0.
- Annul and reset mid-operation:
  - Start, then assert annul_i at cycle 10 -> busy_o drops next cycle; no ready_o; result_o unchanged.
  - A fresh start then completes correctly.
  - rst at cycle 20 of an operation -> all outputs 0, no ready_o.
- Back-to-back operation: assert start_i with new operands during the DONE cycle -> accepted; the second result appears 32 cycles later. A start_i pulse during BUSY is ignored and has no effect on the result.
